load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Parametrised load/store unit. It sits between the core's execute stage and data memory.
//   Accepts one B/H/W(/D) access per handshake and checks alignment.
//   Drives a wait-state-capable memory bus with byte enables, lane-replicated store data and a timeout.
//   Returns sign- or zero-extended load data with an error code.
// PARAMETERS
//   XLEN           32   data width; 32 or 64 only; byte lanes NB = XLEN/8, offset bits OB = log2(NB)
//   ADDR_WIDTH     32   byte-address width
//   TIMEOUT_CYCLES 255  cycles in BUS without mem_ready_i before error; 0 disables timeout
// PORTS
//   clk_i          in   1           single clock, rising edge
//   reset_i        in   1           asynchronous, active-low reset
//   req_valid_i    in   1           access request valid
//   req_ready_o    out  1           unit can accept a request (high only in IDLE)
//   req_write_i    in   1           1 = store, 0 = load
//   req_funct3_i   in   3           RISC-V funct3 size/sign code
//   req_addr_i     in   ADDR_WIDTH  byte address
//   req_wdata_i    in   XLEN        store data (LSBs significant)
//   resp_valid_o   out  1           one-cycle completion pulse
//   resp_rdata_o   out  XLEN        extended load data; 0 for stores and errors
//   resp_error_o   out  2           00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3
//   mem_valid_o    out  1           bus request
//   mem_ready_i    in   1           bus accepts/completes request this cycle
//   mem_write_o    out  1           bus write
//   mem_addr_o     out  ADDR_WIDTH  lane-aligned address (low OB bits zero)
//   mem_byte_en_o  out  NB          byte enables
//   mem_wdata_o    out  XLEN        lane-replicated store data
//   mem_rdata_i    in   XLEN        read data, valid when mem_valid_o & mem_ready_i
// BEHAVIOUR
//   Reset (async, reset_i=0): state IDLE; all outputs 0 except req_ready_o=1; timeout count 0.
//     Reset mid-BUS drops mem_valid_o immediately; no response is produced.
//   Accept on req_valid_i & req_ready_o. Latch write, funct3, address and wdata; inputs are then don't-care.
//   Decode funct3: 000 B, 001 H, 010 W (signed loads), 100 BU, 101 HU.
//     011 D, 110 WU are valid only if XLEN=64. All others are illegal.
//     Signedness is ignored for stores; funct3 1xx on a store is illegal.
//   Misaligned: H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0.
//   FSM:
//     IDLE -> RESP when accepted with an illegal or misaligned access. No bus cycle; error 11/01.
//     IDLE -> BUS when accepted and legal.
//     BUS: mem_valid_o=1; addr/we/byte_en/wdata held stable until mem_ready_i.
//       mem_ready_i=1 -> RESP and capture mem_rdata_i on that edge.
//       Timeout counter counts consecutive BUS cycles with mem_ready_i=0.
//       Count reaching TIMEOUT_CYCLES -> RESP, error 10. mem_ready_i on that same cycle wins (ok).
//     RESP: resp_valid_o=1 for exactly one cycle, no backpressure -> IDLE.
//   req_ready_o=1 only in IDLE, so there is no back-to-back accept.
//   Latency: accept edge -> resp_valid_o 2 cycles later with zero wait states; +1 per wait state.
//     Errors without a bus cycle take 1 cycle.
//   Byte enables: B = 1<<off; H = 2'b11<<off; W = 4'hF<<off; D = all ones; off = addr[OB-1:0].
//   Store data: B byte replicated NB times; H half replicated NB/2; W word replicated; D as-is.
//   Load: select lane at off and sign-extend (B/H/W) or zero-extend (BU/HU/WU) to XLEN.
//   mem_valid_o is never asserted outside BUS; mem_write_o/byte_en/wdata are 0 when mem_valid_o=0.
// TESTING
//   1. XLEN=32, LB addr 0x103, mem_rdata 0x80FF_1234, 0 wait
//      -> byte_en 1000, mem_addr 0x100, resp 2 cycles later, rdata 0xFFFF_FF80, err 00.
//   2. LHU addr 0x102, rdata 0x8001_0000, mem_ready after 3 waits
//      -> resp on cycle 5, rdata 0x0000_8001; mem signals stable throughout.
//   3. SB addr 0x201, wdata 0x1234_56AB -> byte_en 0010, mem_wdata 0xABAB_ABAB, mem_write 1, resp rdata 0.
//   4. LW addr 0x102 -> no mem_valid_o, resp next cycle err 01.
//      funct3 011 with XLEN=32 -> err 11.
//   5. TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid drops, resp err 10 after 4 BUS cycles.
//      Ready on 4th cycle -> err 00.
//   6. Assert reset_i=0 mid-BUS -> mem_valid_o/resp_valid_o 0 immediately, req_ready_o 1.
//      Next request completes normally.
//   Also XLEN=64: LD addr 0x8 full lane; LWU addr 0xC rdata[63:32] zero-extended.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: aligned B/H/W/D access engine between execute stage and a wait-state memory bus
module load_store_unit #(
  parameter int XLEN = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  output logic                  resp_valid_o,
  output logic [XLEN-1:0]       resp_rdata_o,
  output logic [1:0]            resp_error_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [XLEN/8-1:0]     mem_byte_en_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic [XLEN-1:0]       mem_rdata_i
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic [1:0] size, req_size;
  logic uns, illegal, misaligned, timed_out;
  logic [OB-1:0] off, req_off;
  logic [NB-1:0] req_be;
  logic [XLEN-1:0] req_wd, sh, ld_data;
  always_comb begin
    req_off = req_addr_i[OB-1:0];
    req_size = req_funct3_i[1:0];
    illegal = req_funct3_i == 3'b111 || (req_write_i && req_funct3_i[2]) ||
              (XLEN != 64 && (req_size == 2'd3 || req_funct3_i == 3'b110));
    misaligned = (req_size == 2'd1 && req_addr_i[0]) ||
                 (req_size == 2'd2 && req_addr_i[1:0] != 2'b00) ||
                 (req_size == 2'd3 && req_addr_i[2:0] != 3'b000);
    req_be = req_size == 2'd0 ? NB'(1) << req_off :
             req_size == 2'd1 ? NB'(3) << req_off :
             req_size == 2'd2 ? NB'(15) << req_off : '1;
    req_wd = req_size == 2'd0 ? {NB{req_wdata_i[7:0]}} :
             req_size == 2'd1 ? {(NB/2){req_wdata_i[15:0]}} :
             req_size == 2'd2 ? {(XLEN/32){req_wdata_i[31:0]}} : req_wdata_i;
    sh = mem_rdata_i >> {off, 3'b000};
    ld_data = size == 2'd0 ? (uns ? XLEN'(sh[7:0]) : XLEN'($signed(sh[7:0]))) :
              size == 2'd1 ? (uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
              size == 2'd2 ? (uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;
    timed_out = TIMEOUT_CYCLES != 0 && cnt == TW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
      cnt <= '0;
      size <= '0;
      uns <= 1'b0;
      off <= '0;
      req_ready_o <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_error_o <= '0;
      mem_valid_o <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o <= '0;
      mem_byte_en_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          req_ready_o <= 1'b0;
          size <= req_size;
          uns <= req_funct3_i[2];
          off <= req_off;
          cnt <= '0;
          if (illegal || misaligned) begin
            state <= RESP;
            resp_valid_o <= 1'b1;
            resp_error_o <= illegal ? 2'b11 : 2'b01;
          end else begin
            state <= BUS;
            mem_valid_o <= 1'b1;
            mem_write_o <= req_write_i;
            mem_addr_o <= {req_addr_i[ADDR_WIDTH-1:OB], {OB{1'b0}}};
            mem_byte_en_o <= req_be;
            mem_wdata_o <= req_write_i ? req_wd : '0;
          end
        end
        BUS: if (mem_ready_i || timed_out) begin
          // a ready arriving on the final timeout cycle still completes normally
          state <= RESP;
          resp_valid_o <= 1'b1;
          resp_error_o <= mem_ready_i ? 2'b00 : 2'b10;
          resp_rdata_o <= mem_ready_i && !mem_write_o ? ld_data : '0;
          mem_valid_o <= 1'b0;
          mem_write_o <= 1'b0;
          mem_addr_o <= '0;
          mem_byte_en_o <= '0;
          mem_wdata_o <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          req_ready_o <= 1'b1;
          resp_valid_o <= 1'b0;
          resp_rdata_o <= '0;
          resp_error_o <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for 32-bit (short timeout) and 64-bit instances
module tb_load_store_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic req_valid, req_write, mem_ready;
  logic [2:0] req_f3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic req_ready, resp_valid, mem_valid, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [1:0] resp_error;
  logic [3:0] mem_be;
  logic v64, w64, mr64, rr64, rv64, mv64, mw64;
  logic [2:0] f64;
  logic [31:0] a64, ma64;
  logic [63:0] wd64, rd64, rdo64, mwd64;
  logic [1:0] re64;
  logic [7:0] be64;
  typedef struct {logic [63:0] rdata; logic [1:0] err;} exp_t;
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut32 (
    .clk_i(clk), .reset_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_error_o(resp_error),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_byte_en_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  load_store_unit #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut64 (
    .clk_i(clk), .reset_i(rst_n),
    .req_valid_i(v64), .req_ready_o(rr64), .req_write_i(w64),
    .req_funct3_i(f64), .req_addr_i(a64), .req_wdata_i(wd64),
    .resp_valid_o(rv64), .resp_rdata_o(rdo64), .resp_error_o(re64),
    .mem_valid_o(mv64), .mem_ready_i(mr64), .mem_write_o(mw64),
    .mem_addr_o(ma64), .mem_byte_en_o(be64), .mem_wdata_o(mwd64),
    .mem_rdata_i(rd64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req32(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int waits,
                       input logic [31:0] rd, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input int e_lat, input logic [31:0] e_rdata,
                       input logic [1:0] e_err);
    exp_t e;
    int lat;
    int n;
    exp_q.push_back('{64'(e_rdata), e_err});
    chk({tag, " req_ready"}, req_ready, 1);
    req_valid = 1; req_write = w; req_f3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_write = 1'($urandom); req_f3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    n = 0;
    while (mem_valid && n < 50) begin
      chk({tag, " mem_addr"}, mem_addr, e_addr);
      chk({tag, " mem_byte_en"}, mem_be, e_be);
      chk({tag, " mem_write"}, mem_write, w);
      if (w) chk({tag, " mem_wdata"}, mem_wdata, e_wd);
      mem_ready = n == waits;
      mem_rdata = n == waits ? rd : $urandom;
      @(negedge clk);
      lat++;
      n++;
    end
    mem_ready = 0;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " resp_valid"}, resp_valid, 1);
    chk({tag, " latency"}, lat, e_lat);
    e = exp_q.pop_front();
    chk({tag, " resp_rdata"}, resp_rdata, e.rdata);
    chk({tag, " resp_error"}, resp_error, e.err);
    chk({tag, " idle mem_valid"}, mem_valid, 0);
    chk({tag, " idle mem_byte_en"}, mem_be, 0);
    chk({tag, " idle mem_wdata"}, mem_wdata, 0);
    @(negedge clk);
    chk({tag, " resp pulse"}, resp_valid, 0);
    chk({tag, " back ready"}, req_ready, 1);
  endtask

  task automatic req64(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, input logic [7:0] e_be,
                       input logic [63:0] e_wd, input logic [63:0] e_rdata);
    exp_t e;
    exp_q.push_back('{e_rdata, 2'b00});
    v64 = 1; w64 = w; f64 = f3; a64 = a; wd64 = wd;
    @(negedge clk);
    v64 = 0; a64 = $urandom; wd64 = {$urandom, $urandom};
    chk({tag, " mem_valid"}, mv64, 1);
    chk({tag, " mem_addr"}, ma64, {a[31:3], 3'b000});
    chk({tag, " mem_byte_en"}, be64, e_be);
    if (w) chk({tag, " mem_wdata"}, mwd64, e_wd);
    mr64 = 1; rd64 = rd;
    @(negedge clk);
    mr64 = 0; rd64 = {$urandom, $urandom};
    chk({tag, " resp_valid"}, rv64, 1);
    e = exp_q.pop_front();
    chk({tag, " resp_rdata"}, rdo64, e.rdata);
    chk({tag, " resp_error"}, re64, e.err);
    @(negedge clk);
    chk({tag, " back ready"}, rr64, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    req_valid = 0; req_write = 0; req_f3 = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    v64 = 0; w64 = 0; f64 = 0; a64 = 0; wd64 = 0; mr64 = 0; rd64 = 0;
    @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset mem_valid", mem_valid, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset 64 req_ready", rr64, 1);
    rst_n = 1;
    @(negedge clk);
    req32("lb",   0, 3'b000, 32'h103, 0, 0, 32'h80FF1234, 32'h100, 4'b1000, 0, 2, 32'hFFFFFF80, 2'b00);
    req32("lhu",  0, 3'b101, 32'h102, 0, 3, 32'h80010000, 32'h100, 4'b1100, 0, 5, 32'h00008001, 2'b00);
    req32("sb",   1, 3'b000, 32'h201, 32'h123456AB, 0, 32'hFFFFFFFF, 32'h200, 4'b0010, 32'hABABABAB, 2, 0, 2'b00);
    req32("lw mis", 0, 3'b010, 32'h102, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01);
    req32("ld ill", 0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11);
    req32("sbu ill", 1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 0, 0, 1, 0, 2'b11);
    req32("lh",   0, 3'b001, 32'h100, 0, 1, 32'h1234F00D, 32'h100, 4'b0011, 0, 3, 32'hFFFFF00D, 2'b00);
    req32("sh",   1, 3'b001, 32'h202, 32'h0000BEEF, 0, 0, 32'h200, 4'b1100, 32'hBEEFBEEF, 2, 0, 2'b00);
    req32("sw",   1, 3'b010, 32'h204, 32'hDEADBEEF, 2, 0, 32'h204, 4'b1111, 32'hDEADBEEF, 4, 0, 2'b00);
    req32("tmo",  0, 3'b010, 32'h400, 0, 100, 0, 32'h400, 4'b1111, 0, 5, 0, 2'b10);
    req32("tmo edge", 0, 3'b010, 32'h400, 0, 3, 32'hCAFEF00D, 32'h400, 4'b1111, 0, 5, 32'hCAFEF00D, 2'b00);
    req32("lbu",  0, 3'b100, 32'h101, 0, 0, 32'h0000A500, 32'h100, 4'b0010, 0, 2, 32'h000000A5, 2'b00);
    req32("sh mis", 1, 3'b001, 32'h203, 32'h1, 0, 0, 0, 0, 0, 1, 0, 2'b01);
    req_valid = 1; req_write = 0; req_f3 = 3'b010; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 0;
    chk("rst mid-bus mem_valid before", mem_valid, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst mid-bus mem_valid", mem_valid, 0);
    chk("rst mid-bus resp_valid", resp_valid, 0);
    chk("rst mid-bus req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst no resp", resp_valid, 0);
    req32("after rst", 0, 3'b010, 32'h300, 0, 0, 32'h11223344, 32'h300, 4'b1111, 0, 2, 32'h11223344, 2'b00);
    req64("ld",  0, 3'b011, 32'h8, 0, 64'h8123456789ABCDEF, 8'hFF, 0, 64'h8123456789ABCDEF);
    req64("lwu", 0, 3'b110, 32'hC, 0, 64'h89ABCDEF01234567, 8'hF0, 0, 64'h0000000089ABCDEF);
    req64("lw",  0, 3'b010, 32'hC, 0, 64'h89ABCDEF01234567, 8'hF0, 0, 64'hFFFFFFFF89ABCDEF);
    req64("lhu", 0, 3'b101, 32'h6, 0, 64'h1234800100000000, 8'hC0, 0, 64'h0000000000001234);
    req64("sw",  1, 3'b010, 32'h14, 64'h00000000CAFEBABE, 0, 8'hF0, 64'hCAFEBABECAFEBABE, 0);
    req64("sd",  1, 3'b011, 32'h10, 64'h0123456789ABCDEF, 0, 8'hFF, 64'h0123456789ABCDEF, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
